// File: rtl/apb_slave_regs.sv
// APB3 completer with a bank of NUM_REGS read/write registers, programmable wait states and pslverr.
// Optional: define APB_SLAVE_ID_REG_EN to make index 0 a read-only ID register.
module apb_slave_regs #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned           IDX_W    = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LP_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
`ifdef APB_SLAVE_ID_REG_EN
    localparam logic [31:0]           LP_ID    = 32'hA5B3_0001;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  w_ready;
    logic                  w_done;
    logic                  w_err;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_idx   = r_addr[IDX_W+1:2];
    assign w_ready = (r_state == ST_ACCESS) && (r_wait_cnt == '0);
    assign w_done  = w_ready && psel && penable;

`ifdef APB_SLAVE_ID_REG_EN
    assign w_err = (r_addr[1:0] != 2'b00) || (r_addr >= LP_LIMIT) ||
                   (r_write && (w_idx == '0));
`else
    assign w_err = (r_addr[1:0] != 2'b00) || (r_addr >= LP_LIMIT);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // psel&penable without a preceding setup phase is ignored
                if (psel && !penable) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!psel)       w_state_nxt = ST_IDLE;
                else if (w_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
        end else if (r_state == ST_IDLE && psel && !penable) begin
            r_wait_cnt <= 8'(WAIT_CYCLES);
            r_addr     <= paddr;
            r_write    <= pwrite;
            r_wdata    <= pwdata;
        end else if (r_state == ST_ACCESS && psel && penable && r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_done && r_write && !w_err) begin
            r_regs[w_idx] <= r_wdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_ready && !w_err) begin
`ifdef APB_SLAVE_ID_REG_EN
            if (w_idx == '0) w_rdata = DATA_WIDTH'(LP_ID);
            else             w_rdata = r_regs[w_idx];
`else
            w_rdata = r_regs[w_idx];
`endif
        end
    end

    assign prdata  = w_rdata;
    assign pready  = w_ready;
    assign pslverr = w_ready && w_err;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: one instance with no wait states, one with three.
module tb_apb_slave_regs;

    logic        pclk;
    logic        presetn;
    logic        psel0, psel3;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [31:0] exp0 [16];
    logic [31:0] exp3 [16];

    apb_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(3)) u_dut3 (
        .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int unsigned sel, input int unsigned idx);
`ifdef APB_SLAVE_ID_REG_EN
        if (idx == 0) return 32'hA5B3_0001;
`endif
        return (sel == 0) ? exp0[idx] : exp3[idx];
    endfunction

    function automatic logic cur_ready(input int unsigned sel);
        return (sel == 0) ? pready0 : pready3;
    endfunction

    task automatic apb_xfer(input int unsigned sel, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic wr, output logic [31:0] rdata, output logic slverr,
                            output int unsigned waits);
        @(posedge pclk); #1;
        psel0 = (sel == 0); psel3 = (sel == 3);
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        while (!cur_ready(sel) && waits < 20) begin
            @(posedge pclk); #1;
            waits++;
        end
        rdata  = (sel == 0) ? prdata0 : prdata3;
        slverr = (sel == 0) ? pslverr0 : pslverr3;
        @(posedge pclk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    task automatic do_read(input int unsigned sel, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_err, input string tag);
        logic [31:0] rd; logic se; int unsigned w;
        apb_xfer(sel, addr, 32'h0, 1'b0, rd, se, w);
        check_eq({tag, "_data"}, rd, exp_data);
        check_eq({tag, "_err"}, {31'd0, se}, {31'd0, exp_err});
        check_eq({tag, "_waits"}, w, (sel == 0) ? 32'd0 : 32'd3);
    endtask

    task automatic do_write(input int unsigned sel, input logic [31:0] addr,
                            input logic [31:0] data, input logic exp_err, input string tag);
        logic [31:0] rd; logic se; int unsigned w;
        apb_xfer(sel, addr, data, 1'b1, rd, se, w);
        check_eq({tag, "_err"}, {31'd0, se}, {31'd0, exp_err});
        check_eq({tag, "_prdata"}, rd, 32'h0);
        check_eq({tag, "_waits"}, w, (sel == 0) ? 32'd0 : 32'd3);
    endtask

    task automatic dump_all(input int unsigned sel, input string tag);
        for (int i = 0; i < 16; i++)
            do_read(sel, 32'(i * 4), exp_rd(sel, i), 1'b0, $sformatf("%s_r%0d", tag, i));
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        for (int i = 0; i < 16; i++) begin exp0[i] = '0; exp3[i] = '0; end
        presetn = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge pclk);
        #1;
        check_eq("rst_pready", {30'd0, pready3, pready0}, 32'h0);
        check_eq("rst_pslverr", {30'd0, pslverr3, pslverr0}, 32'h0);
        check_eq("rst_prdata0", prdata0, 32'h0);
        presetn = 1'b1;
        @(posedge pclk); #1;
        check_eq("post_rst_pready", {30'd0, pready3, pready0}, 32'h0);

        // 1: all registers read zero, no wait states
        dump_all(0, "t1");

        // psel&penable without setup must be ignored
        @(posedge pclk); #1;
        psel0 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h8;
        @(posedge pclk); #1;
        check_eq("nosetup_ready_a", {31'd0, pready0}, 32'h0);
        @(posedge pclk); #1;
        check_eq("nosetup_ready_b", {31'd0, pready0}, 32'h0);
        psel0 = 1'b0; penable = 1'b0;

        // 2: write/read back
        do_write(0, 32'h8, 32'hDEADBEEF, 1'b0, "t2_wr");
        exp0[2] = 32'hDEADBEEF;
        do_read(0, 32'h8, 32'hDEADBEEF, 1'b0, "t2_rd8");
        do_read(0, 32'h4, 32'h0, 1'b0, "t2_rd4");
        do_read(0, 32'hC, 32'h0, 1'b0, "t2_rdC");
        do_write(0, 32'h3C, 32'hCAFE_0F0F, 1'b0, "t2_wr_last");
        exp0[15] = 32'hCAFE_0F0F;
        do_read(0, 32'h3C, 32'hCAFE_0F0F, 1'b0, "t2_rd_last");

`ifdef APB_SLAVE_ID_REG_EN
        // 6: ID register is read-only
        do_read(0, 32'h0, 32'hA5B3_0001, 1'b0, "t6_id_rd");
        do_write(0, 32'h0, 32'h1111_2222, 1'b1, "t6_id_wr");
        do_read(0, 32'h0, 32'hA5B3_0001, 1'b0, "t6_id_rd2");
`else
        do_write(0, 32'h0, 32'h0BAD_F00D, 1'b0, "t2_wr0");
        exp0[0] = 32'h0BAD_F00D;
        do_read(0, 32'h0, 32'h0BAD_F00D, 1'b0, "t2_rd0");
`endif

        // 3: three wait states, update only on the completing edge
        @(posedge pclk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h12345678;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("t3_wait%0d_ready", k), {31'd0, pready3}, 32'h0);
            check_eq($sformatf("t3_wait%0d_reg", k), u_dut3.r_regs[4], 32'h0);
            @(posedge pclk); #1;
        end
        check_eq("t3_ready4", {31'd0, pready3}, 32'h1);
        check_eq("t3_err4", {31'd0, pslverr3}, 32'h0);
        check_eq("t3_reg_before", u_dut3.r_regs[4], 32'h0);
        @(posedge pclk); #1;
        psel3 = 1'b0; penable = 1'b0;
        check_eq("t3_reg_after", u_dut3.r_regs[4], 32'h12345678);
        check_eq("t3_ready_idle", {31'd0, pready3}, 32'h0);
        exp3[4] = 32'h12345678;
        do_read(3, 32'h10, 32'h12345678, 1'b0, "t3_rd");

        // 4: error transfers leave registers untouched
        do_write(0, 32'h40, 32'hFFFF_FFFF, 1'b1, "t4_wr_oor");
        do_write(0, 32'h6, 32'hFFFF_FFFF, 1'b1, "t4_wr_mis");
        do_read(0, 32'h40, 32'h0, 1'b1, "t4_rd_oor");
        do_read(0, 32'h9, 32'h0, 1'b1, "t4_rd_mis");
        dump_all(0, "t4");

        // 5a: abort a write by dropping psel in the first wait state
        @(posedge pclk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h5555_AAAA;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel3 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        check_eq("t5_abort_ready", {31'd0, pready3}, 32'h0);
        do_read(3, 32'h14, 32'h0, 1'b0, "t5_abort_rd");

        // 5b: reset during ACCESS
        @(posedge pclk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h7777_8888;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        check_eq("t5_rst_ready", {31'd0, pready3}, 32'h0);
        check_eq("t5_rst_reg", u_dut3.r_regs[6], 32'h0);
        psel3 = 1'b0; penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
        for (int i = 0; i < 16; i++) begin exp0[i] = '0; exp3[i] = '0; end
        dump_all(3, "t5_d3");
        dump_all(0, "t5_d0");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
- APB3 completer that sits directly downstream of the team's APB master and responds to its psel/penable/pwrite/paddr/pwdata transfers.
- Implements a bank of NUM_REGS word-wide read/write registers.
- Programmable wait states and error signalling let the master's ACCESS-stall and error paths be exercised end to end.

Parameters:
DATA_WIDTH, 32, width of pwdata/prdata and of each register
ADDR_WIDTH, 32, width of paddr
NUM_REGS, 16, number of registers, power of two, >=2
WAIT_CYCLES, 0, pready-low cycles inserted in every ACCESS phase (0..255)

Ports:
pclk  in  1  clock
presetn  in  1  asynchronous active-low reset
psel  in  1  slave select from master
penable  in  1  access-phase indicator
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
prdata  out  DATA_WIDTH  read data, valid only when pready=1 in ACCESS
pready  out  1  transfer-complete strobe
pslverr  out  1  error flag, valid only with pready=1

Behaviour:
- Clock and reset: one clock, pclk. Reset is asynchronous and active-low on presetn.
- Reset clears all registers to 0, state to IDLE and wait counter to 0. prdata, pready and pslverr are 0 during reset and immediately after it.
- States:
  - IDLE: psel=1 and penable=0 (setup phase) -> ACCESS. On that edge, load wait_cnt=WAIT_CYCLES and latch paddr, pwrite and pwdata.
  - ACCESS: pready = (wait_cnt==0), combinational from registered state. While wait_cnt!=0 and psel&penable, decrement each cycle. When psel&penable&pready, the transfer completes and the next state is IDLE.
- Latency: ACCESS lasts exactly WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, pready=1 in the first ACCESS cycle.
- Address decode uses the latched address:
  - Index = addr[$clog2(NUM_REGS)+1:2].
  - err = (addr[1:0]!=0) or (addr >= NUM_REGS*4).
- Write: the register is updated on the completing edge only, and only if err=0.
- Read: prdata = reg[index] while pready=1 and err=0; otherwise prdata=0.
- pslverr = err & pready; 0 at all other times. An errored transfer never modifies any register.
- pready, prdata and pslverr are 0 in IDLE.
- Protocol violations:
  - psel falls during ACCESS before completion (abort): return to IDLE, no write, outputs 0.
  - psel&penable seen in IDLE without a prior setup phase: ignored, pready stays 0.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted normally. The minimum transfer period is 2 cycles.
- Reset asserted mid-ACCESS: immediate return to IDLE, registers cleared, the pending write is lost.
- Registers are full DATA_WIDTH; there are no byte strobes (APB3).

Optional Feature:
- Macro APB_SLAVE_ID_REG_EN.
- When defined:
  - Register index 0 is a read-only ID register returning the constant 32'hA5B3_0001, zero-extended or truncated to DATA_WIDTH.
  - Writes to index 0 complete with pslverr=1 and no state change.
  - Indices 1..NUM_REGS-1 behave as normal.
- When undefined, index 0 is an ordinary read/write register, reset to 0.

Test Plan:
1. Reset, then read 0x0 through 0x3C (WAIT_CYCLES=0) -> every read returns 0, pready=1 in the first ACCESS cycle, pslverr=0.
2. Write 0xDEADBEEF to 0x8, then read 0x8 -> read returns 0xDEADBEEF; 0x4 and 0xC still read 0.
3. WAIT_CYCLES=3: write 0x12345678 to 0x10 -> pready is low for 3 ACCESS cycles and high on the 4th; the register updates only on that 4th edge; a readback matches.
4. Write to 0x40 (out of range) and to 0x6 (misaligned) -> pslverr=1 with pready, prdata=0, and a dump of all 16 registers shows no change.
5. Abort: drop psel during wait state 1 of a write to 0x14, then assert presetn low mid-ACCESS on a later write -> no register update, pready=0; after reset all registers read 0.
6. With APB_SLAVE_ID_REG_EN defined: read 0x0 -> 0xA5B30001; write 0x0 -> pslverr=1 and a re-read still returns 0xA5B30001.
